// File: rtl/sar_approx_ctrl8.sv
// 8-bit successive-approximation / tracking controller driving the SAR DAC code.
// Optional build macro SAR_TRACK_HYST_EN: TRACK steps only after two agreeing comparator samples.
module sar_approx_ctrl8 (
  input  logic       ClockT,
  input  logic       ResetN,
  input  logic       Start,
  input  logic       TrackEn,
  input  logic       CmpOut,
  output logic [7:0] SAROut,
  output logic [1:0] StateP,
  output logic       Inc,
  output logic       Dcr,
  output logic       Busy,
  output logic       EOC
);

  // Encoding doubles as the published phase code.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StConv  = 2'b01,
    StDone  = 2'b11,
    StTrack = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sar_q, sar_d;
  logic [2:0] bit_q, bit_d;
  logic       inc_q, inc_d;
  logic       dcr_q, dcr_d;
  logic       busy_q, busy_d;
  logic       eoc_q, eoc_d;
  logic       step_ok;

`ifdef SAR_TRACK_HYST_EN
  // hyst_q = {last polarity, one unconsumed sample of that polarity}
  logic [1:0] hyst_q, hyst_d;
  assign step_ok = hyst_q[0] && (hyst_q[1] == CmpOut);
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge ClockT or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= StIdle;
      sar_q   <= 8'h00;
      bit_q   <= 3'd7;
      inc_q   <= 1'b0;
      dcr_q   <= 1'b0;
      busy_q  <= 1'b0;
      eoc_q   <= 1'b0;
`ifdef SAR_TRACK_HYST_EN
      hyst_q  <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      sar_q   <= sar_d;
      bit_q   <= bit_d;
      inc_q   <= inc_d;
      dcr_q   <= dcr_d;
      busy_q  <= busy_d;
      eoc_q   <= eoc_d;
`ifdef SAR_TRACK_HYST_EN
      hyst_q  <= hyst_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (Start) state_d = StConv;
      StConv:  if (bit_q == 3'd0) state_d = StDone;
      StDone:  state_d = TrackEn ? StTrack : StIdle;
      StTrack: begin
        if (Start) begin
          state_d = StConv;
        end else if (!TrackEn) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sar_d = sar_q;
    bit_d = bit_q;
    inc_d = 1'b0;
    dcr_d = 1'b0;
`ifdef SAR_TRACK_HYST_EN
    hyst_d = hyst_q;
`endif
    case (state_q)
      StIdle: begin
        if (Start) begin
          sar_d = 8'h80;
          bit_d = 3'd7;
        end
      end
      StConv: begin
        sar_d[bit_q] = CmpOut;
        if (bit_q != 3'd0) begin
          sar_d[bit_q - 3'd1] = 1'b1;
          bit_d = bit_q - 3'd1;
        end
      end
      StTrack: begin
        if (Start) begin
          sar_d = 8'h80;
          bit_d = 3'd7;
        end else if (TrackEn) begin
          if (step_ok) begin
            if (CmpOut && (sar_q != 8'hFF)) begin
              sar_d = sar_q + 8'd1;
              inc_d = 1'b1;
            end else if (!CmpOut && (sar_q != 8'h00)) begin
              sar_d = sar_q - 8'd1;
              dcr_d = 1'b1;
            end
`ifdef SAR_TRACK_HYST_EN
            hyst_d = 2'b00;
          end else begin
            hyst_d = {CmpOut, 1'b1};
`endif
          end
        end
      end
      default: ;
    endcase
`ifdef SAR_TRACK_HYST_EN
    if (state_d != StTrack) hyst_d = 2'b00;
`endif
    busy_d = (state_d == StConv);
    eoc_d  = (state_d == StDone);
  end

  assign SAROut = sar_q;
  assign StateP = state_q;
  assign Inc    = inc_q;
  assign Dcr    = dcr_q;
  assign Busy   = busy_q;
  assign EOC    = eoc_q;

endmodule

// File: tb/tb_sar_approx_ctrl8.sv
// Directed bench for sar_approx_ctrl8 with an ideal comparator model (Vin >= DAC code).
module tb_sar_approx_ctrl8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       track_en;
  logic       cmp;
  logic [7:0] vin;
  logic       ovr_en;
  logic       ovr_val;
  logic [7:0] sar_out;
  logic [1:0] state_p;
  logic       inc;
  logic       dcr;
  logic       busy;
  logic       eoc;
  logic [13:0] outs;

  int total;
  int bad;

  sar_approx_ctrl8 dut (
    .ClockT (clk),
    .ResetN (rst_n),
    .Start  (start),
    .TrackEn(track_en),
    .CmpOut (cmp),
    .SAROut (sar_out),
    .StateP (state_p),
    .Inc    (inc),
    .Dcr    (dcr),
    .Busy   (busy),
    .EOC    (eoc)
  );

  assign cmp  = ovr_en ? ovr_val : (vin >= sar_out);
  assign outs = {state_p, sar_out, inc, dcr, busy, eoc};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    step();
    total++;
    if (outs !== 14'h0) begin
      bad++;
      $display("FAIL reset_values: got %h want %h", outs, 14'h0);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (outs !== 14'h0) begin
      bad++;
      $display("FAIL idle_after_release: got %h want %h", outs, 14'h0);
    end
  endtask

  task automatic test_conv_a5();
    logic [7:0] exp_seq [8];
    exp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vin = 8'hA5;
    track_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      total++;
      if (outs !== {2'b01, exp_seq[i], 4'b0010}) begin
        bad++;
        $display("FAIL a5_conv_cycle%0d: got %h want %h", i, outs, {2'b01, exp_seq[i], 4'b0010});
      end
    end
    step();
    total++;
    if (outs !== {2'b11, 8'hA5, 4'b0001}) begin
      bad++;
      $display("FAIL a5_done: got %h want %h", outs, {2'b11, 8'hA5, 4'b0001});
    end
    step();
    total++;
    if (outs !== {2'b00, 8'hA5, 4'b0000}) begin
      bad++;
      $display("FAIL a5_back_idle: got %h want %h", outs, {2'b00, 8'hA5, 4'b0000});
    end
  endtask

  // Full conversion of v; optionally holds Start through CONV/DONE and ends in TRACK.
  task automatic test_conversion(input logic [7:0] v, input logic hold, input logic trk);
    logic [1:0] end_state;
    end_state = trk ? 2'b10 : 2'b00;
    vin = v;
    track_en = trk;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    total++;
    if (sar_out !== 8'h80) begin
      bad++;
      $display("FAIL conv_%h_first_code: got %h want %h", v, sar_out, 8'h80);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      total++;
      if ({state_p, busy, eoc} !== 4'b0110) begin
        bad++;
        $display("FAIL conv_%h_phase%0d: got %b want %b", v, i, {state_p, busy, eoc}, 4'b0110);
      end
    end
    step();
    total++;
    if (outs !== {2'b11, v, 4'b0001}) begin
      bad++;
      $display("FAIL conv_%h_done: got %h want %h", v, outs, {2'b11, v, 4'b0001});
    end
    step();
    start = 1'b0;
    total++;
    if (outs !== {end_state, v, 4'b0000}) begin
      bad++;
      $display("FAIL conv_%h_after_done: got %h want %h", v, outs, {end_state, v, 4'b0000});
    end
  endtask

`ifndef SAR_TRACK_HYST_EN
  task automatic test_track();
    logic [7:0] e;
    test_conversion(8'hA5, 1'b0, 1'b1);
    vin = 8'hA8;
    for (int i = 0; i < 3; i++) begin
      step();
      e = 8'hA6 + 8'(i);
      total++;
      if (outs !== {2'b10, e, 4'b1000}) begin
        bad++;
        $display("FAIL track_inc%0d: got %h want %h", i, outs, {2'b10, e, 4'b1000});
      end
    end
    vin = 8'hA6;
    for (int i = 0; i < 2; i++) begin
      step();
      e = 8'hA7 - 8'(i);
      total++;
      if (outs !== {2'b10, e, 4'b0100}) begin
        bad++;
        $display("FAIL track_dcr%0d: got %h want %h", i, outs, {2'b10, e, 4'b0100});
      end
    end
    track_en = 1'b0;
    step();
    total++;
    if (outs !== {2'b00, 8'hA6, 4'b0000}) begin
      bad++;
      $display("FAIL track_exit: got %h want %h", outs, {2'b00, 8'hA6, 4'b0000});
    end
  endtask
`endif

  task automatic test_saturation();
    test_conversion(8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (outs !== {2'b10, 8'hFF, 4'b0000}) begin
        bad++;
        $display("FAIL sat_ff%0d: got %h want %h", i, outs, {2'b10, 8'hFF, 4'b0000});
      end
    end
    track_en = 1'b0;
    step();
    test_conversion(8'h00, 1'b0, 1'b1);
    ovr_en = 1'b1;
    ovr_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (outs !== {2'b10, 8'h00, 4'b0000}) begin
        bad++;
        $display("FAIL sat_00_%0d: got %h want %h", i, outs, {2'b10, 8'h00, 4'b0000});
      end
    end
    ovr_en = 1'b0;
    track_en = 1'b0;
    step();
    total++;
    if (outs !== 14'h0) begin
      bad++;
      $display("FAIL sat_exit: got %h want %h", outs, 14'h0);
    end
  endtask

  task automatic test_reset_midconv();
    vin = 8'h5A;
    track_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 14'h0) begin
      bad++;
      $display("FAIL midconv_async_reset: got %h want %h", outs, 14'h0);
    end
    step();
    total++;
    if (outs !== 14'h0) begin
      bad++;
      $display("FAIL midconv_reset_held: got %h want %h", outs, 14'h0);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (outs !== 14'h0) begin
      bad++;
      $display("FAIL midconv_no_restart: got %h want %h", outs, 14'h0);
    end
    test_conversion(8'h5A, 1'b0, 1'b0);
  endtask

`ifdef SAR_TRACK_HYST_EN
  task automatic test_hyst();
    logic [7:0] e;
    logic       ei;
    test_conversion(8'h80, 1'b0, 1'b1);
    ovr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ovr_val = (i % 2 == 0);
      step();
      total++;
      if (outs !== {2'b10, 8'h80, 4'b0000}) begin
        bad++;
        $display("FAIL hyst_dither%0d: got %h want %h", i, outs, {2'b10, 8'h80, 4'b0000});
      end
    end
    ovr_val = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      e = 8'h80 + 8'((j + 1) / 2);
      ei = (j % 2 == 1);
      total++;
      if (outs !== {2'b10, e, ei, 3'b000}) begin
        bad++;
        $display("FAIL hyst_hold%0d: got %h want %h", j, outs, {2'b10, e, ei, 3'b000});
      end
    end
    ovr_en = 1'b0;
    track_en = 1'b0;
    step();
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    start = 1'b0;
    track_en = 1'b0;
    vin = 8'h00;
    ovr_en = 1'b0;
    ovr_val = 1'b0;
    total = 0;
    bad = 0;
    test_reset();
    test_conv_a5();
    test_conversion(8'h00, 1'b1, 1'b0);
    test_conversion(8'hFF, 1'b1, 1'b0);
`ifndef SAR_TRACK_HYST_EN
    test_track();
`else
    test_hyst();
`endif
    test_saturation();
    test_reset_midconv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
